// File: rtl/objects_pkg.sv
// Shared definitions for the video-path objects: default colour width,
// the configuration FSM state type and the power-up rank table.
package objects_pkg;

    localparam int RGB_W_DEFAULT = 8;

    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } cfg_state_t;

    // Power-up rank of a layer: its own index, so layer 0 is on top.
    function automatic logic [7:0] default_rank(input int unsigned idx);
        return idx[7:0];
    endfunction

endpackage

// File: rtl/layer_priority_select.sv
// Combinational winner selection: the eligible layer with the smallest rank
// wins; on equal ranks the lower index wins.
module layer_priority_select
    import objects_pkg::*;
#(
    parameter int NUM_LAYERS = 4,
    parameter int IW         = $clog2(NUM_LAYERS)
) (
    input  logic [NUM_LAYERS-1:0]    eligible,
    input  logic [NUM_LAYERS*IW-1:0] rankTable,
    output logic                     winnerValid,
    output logic [IW-1:0]            winnerLayer
);

    logic [IW-1:0] best_rank;

    // Scan from index 0 upward; a strict less-than keeps the earlier
    // (lower-index) layer when ranks tie.
    always_comb begin
        winnerValid = 1'b0;
        winnerLayer = '0;
        best_rank   = '0;
        for (int i = 0; i < NUM_LAYERS; i++) begin
            if (eligible[i] && (!winnerValid || rankTable[i*IW +: IW] < best_rank)) begin
                winnerValid = 1'b1;
                winnerLayer = IW'(i);
                best_rank   = rankTable[i*IW +: IW];
            end
        end
    end

endmodule

// File: rtl/layer_priority_arbiter.sv
// Per-pixel sprite layer arbiter. Picks the winning layer each clock,
// registers its colour (or the background), double-buffers rank/enable
// updates to frame boundaries and latches per-frame layer overlap.
//
// Config handshake: a write transfers on a rising clk edge where
// cfgValid && cfgReady. cfgValid may be raised at any time and the
// payload (cfgLayer/cfgEnable/cfgRank) must be stable while cfgValid is
// high; cfgReady is low from the cycle after an accepted in-range write
// until the cycle after the next startOfFrame.
module layer_priority_arbiter
    import objects_pkg::*;
#(
    parameter int NUM_LAYERS = 4,
    parameter int RGB_W      = RGB_W_DEFAULT,
    localparam int IW        = $clog2(NUM_LAYERS)
) (
    input  logic                        clk,
    input  logic                        resetN,
    input  logic                        startOfFrame,
    input  logic [NUM_LAYERS-1:0]       drawingRequest,
    input  logic [NUM_LAYERS*RGB_W-1:0] layerRGB,
    input  logic [RGB_W-1:0]            backGroundRGB,
    input  logic                        cfgValid,
    output logic                        cfgReady,
    input  logic [IW-1:0]               cfgLayer,
    input  logic                        cfgEnable,
    input  logic [IW-1:0]               cfgRank,
    output logic [RGB_W-1:0]            RGBOut,
    output logic                        winnerValid,
    output logic [IW-1:0]               winnerLayer,
    output logic [NUM_LAYERS-1:0]       collisionMask,
    output logic                        collisionValid
);

    localparam logic [IW:0] NUM_L = NUM_LAYERS[IW:0];

    // Active tables, shadow entry and config FSM state
    cfg_state_t                 state_q;
    logic                       cfg_ready_q;
    logic [NUM_LAYERS-1:0]      active_en_q;
    logic [NUM_LAYERS*IW-1:0]   active_rank_q;
    logic [IW-1:0]              sh_layer_q;
    logic                       sh_en_q;
    logic [IW-1:0]              sh_rank_q;

    // Pixel path
    logic [NUM_LAYERS-1:0]      eligible;
    logic                       sel_valid;
    logic [IW-1:0]              sel_layer;
    logic [RGB_W-1:0]           win_rgb;
    logic [RGB_W-1:0]           rgb_q;
    logic                       win_valid_q;
    logic [IW-1:0]              win_layer_q;

    // Collision tracking
    logic [3:0]                 elig_cnt;
    logic [NUM_LAYERS-1:0]      coll_now;
    logic [NUM_LAYERS-1:0]      coll_acc_q;
    logic [NUM_LAYERS-1:0]      coll_mask_q;
    logic                       coll_valid_q;

    logic                       cfg_layer_ok;

    assign eligible     = drawingRequest & active_en_q;
    assign cfg_layer_ok = {1'b0, cfgLayer} < NUM_L;

    layer_priority_select #(
        .NUM_LAYERS (NUM_LAYERS),
        .IW         (IW)
    ) u_select (
        .eligible    (eligible),
        .rankTable   (active_rank_q),
        .winnerValid (sel_valid),
        .winnerLayer (sel_layer)
    );

    // Mux the winning layer's colour, falling back to the background
    always_comb begin
        win_rgb = backGroundRGB;
        for (int i = 0; i < NUM_LAYERS; i++) begin
            if (sel_valid && sel_layer == IW'(i)) begin
                win_rgb = layerRGB[i*RGB_W +: RGB_W];
            end
        end
    end

    // A layer collides when it is eligible together with at least one other
    always_comb begin
        elig_cnt = '0;
        for (int i = 0; i < NUM_LAYERS; i++) begin
            if (eligible[i]) begin
                elig_cnt = elig_cnt + 4'd1;
            end
        end
        coll_now = (elig_cnt >= 4'd2) ? eligible : '0;
    end

    // Register the pixel result: one cycle latency, no stalls
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            rgb_q       <= '0;
            win_valid_q <= 1'b0;
            win_layer_q <= '0;
        end else begin
            rgb_q       <= win_rgb;
            win_valid_q <= sel_valid;
            win_layer_q <= sel_layer;
        end
    end

    // Config FSM: capture one write into the shadow entry, commit it at the
    // end of the next startOfFrame cycle. A capture during a startOfFrame
    // cycle waits for the following boundary because IDLE never commits.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q     <= IDLE;
            cfg_ready_q <= 1'b1;
            sh_layer_q  <= '0;
            sh_en_q     <= 1'b0;
            sh_rank_q   <= '0;
            active_en_q <= '1;
            for (int i = 0; i < NUM_LAYERS; i++) begin
                active_rank_q[i*IW +: IW] <= IW'(default_rank(i));
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (cfgValid && cfg_layer_ok) begin
                        sh_layer_q  <= cfgLayer;
                        sh_en_q     <= cfgEnable;
                        sh_rank_q   <= cfgRank;
                        state_q     <= PENDING;
                        cfg_ready_q <= 1'b0;
                    end
                end
                PENDING: begin
                    if (startOfFrame) begin
                        for (int i = 0; i < NUM_LAYERS; i++) begin
                            if (sh_layer_q == IW'(i)) begin
                                active_en_q[i]            <= sh_en_q;
                                active_rank_q[i*IW +: IW] <= sh_rank_q;
                            end
                        end
                        state_q     <= IDLE;
                        cfg_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    cfg_ready_q <= 1'b1;
                end
            endcase
        end
    end

    // Accumulate overlap during the frame and publish it at the boundary,
    // including the startOfFrame cycle's own collisions
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            coll_acc_q   <= '0;
            coll_mask_q  <= '0;
            coll_valid_q <= 1'b0;
        end else if (startOfFrame) begin
            coll_mask_q  <= coll_acc_q | coll_now;
            coll_valid_q <= 1'b1;
            coll_acc_q   <= '0;
        end else begin
            coll_acc_q   <= coll_acc_q | coll_now;
            coll_valid_q <= 1'b0;
        end
    end

    assign cfgReady       = cfg_ready_q;
    assign RGBOut         = rgb_q;
    assign winnerValid    = win_valid_q;
    assign winnerLayer    = win_layer_q;
    assign collisionMask  = coll_mask_q;
    assign collisionValid = coll_valid_q;

endmodule

// File: tb/tb_layer_priority_arbiter.sv
// Bench for layer_priority_arbiter: directed scenarios and random traffic
// against a behavioural model, plus a 5-layer instance for out-of-range writes.
module tb_layer_priority_arbiter;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int IW = 2;

    // Clock and reset
    logic clk = 1'b0;
    logic resetN;
    always #5 clk = ~clk;

    // 4-layer DUT signals
    logic            sof;
    logic [N-1:0]    req;
    logic [N*W-1:0]  rgb_in;
    logic [W-1:0]    bg;
    logic            cfg_v;
    logic            cfg_rdy;
    logic [IW-1:0]   cfg_l;
    logic            cfg_e;
    logic [IW-1:0]   cfg_r;
    logic [W-1:0]    rgb_out;
    logic            wv;
    logic [IW-1:0]   wl;
    logic [N-1:0]    cmask;
    logic            cvalid;

    // 5-layer DUT signals
    logic            sof5;
    logic [4:0]      req5;
    logic [39:0]     rgb_in5;
    logic            cfg_v5;
    logic            cfg_rdy5;
    logic [2:0]      cfg_l5;
    logic            cfg_e5;
    logic [2:0]      cfg_r5;
    logic [W-1:0]    rgb_out5;
    logic            wv5;
    logic [2:0]      wl5;
    logic [4:0]      cmask5;
    logic            cvalid5;

    layer_priority_arbiter #(.NUM_LAYERS(N), .RGB_W(W)) dut (
        .clk            (clk),
        .resetN         (resetN),
        .startOfFrame   (sof),
        .drawingRequest (req),
        .layerRGB       (rgb_in),
        .backGroundRGB  (bg),
        .cfgValid       (cfg_v),
        .cfgReady       (cfg_rdy),
        .cfgLayer       (cfg_l),
        .cfgEnable      (cfg_e),
        .cfgRank        (cfg_r),
        .RGBOut         (rgb_out),
        .winnerValid    (wv),
        .winnerLayer    (wl),
        .collisionMask  (cmask),
        .collisionValid (cvalid)
    );

    layer_priority_arbiter #(.NUM_LAYERS(5), .RGB_W(W)) dut5 (
        .clk            (clk),
        .resetN         (resetN),
        .startOfFrame   (sof5),
        .drawingRequest (req5),
        .layerRGB       (rgb_in5),
        .backGroundRGB  (8'h5A),
        .cfgValid       (cfg_v5),
        .cfgReady       (cfg_rdy5),
        .cfgLayer       (cfg_l5),
        .cfgEnable      (cfg_e5),
        .cfgRank        (cfg_r5),
        .RGBOut         (rgb_out5),
        .winnerValid    (wv5),
        .winnerLayer    (wl5),
        .collisionMask  (cmask5),
        .collisionValid (cvalid5)
    );

    // Scoreboard counters and checker
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Behavioural model state
    int       m_en[N];
    int       m_rk[N];
    bit       m_pend;
    int       m_sh_l, m_sh_e, m_sh_r;
    bit [N-1:0] m_acc;
    logic [W-1:0]  e_rgb;
    logic          e_wv;
    logic [IW-1:0] e_wl;
    logic          e_ready;
    logic [N-1:0]  e_cmask;
    logic          e_cvalid;

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_en[i] = 1;
            m_rk[i] = i;
        end
        m_pend   = 1'b0;
        m_acc    = '0;
        e_rgb    = '0;
        e_wv     = 1'b0;
        e_wl     = '0;
        e_ready  = 1'b1;
        e_cmask  = '0;
        e_cvalid = 1'b0;
    endtask

    task automatic check_all(input string where);
        check({where, ".rgb"},    32'(rgb_out), 32'(e_rgb));
        check({where, ".wv"},     32'(wv),      32'(e_wv));
        check({where, ".wl"},     32'(wl),      32'(e_wl));
        check({where, ".ready"},  32'(cfg_rdy), 32'(e_ready));
        check({where, ".cmask"},  32'(cmask),   32'(e_cmask));
        check({where, ".cvalid"}, 32'(cvalid),  32'(e_cvalid));
    endtask

    // One clock: predict from current inputs, advance the model, compare
    // after the edge, then drop the single-cycle pulses.
    task automatic step(input string where);
        int         best     = -1;
        int         best_key = 1 << 30;
        int         cnt      = 0;
        bit [N-1:0] elig     = '0;
        bit [N-1:0] coll;
        bit         old_pend;
        for (int i = 0; i < N; i++) begin
            if (req[i] && m_en[i] == 1) begin
                elig[i] = 1'b1;
                cnt++;
                if (m_rk[i] * 16 + i < best_key) begin
                    best_key = m_rk[i] * 16 + i;
                    best     = i;
                end
            end
        end
        e_wv  = (best >= 0);
        e_wl  = (best >= 0) ? IW'(best) : '0;
        e_rgb = (best >= 0) ? rgb_in[best*W +: W] : bg;
        coll  = (cnt >= 2) ? elig : '0;
        if (sof) begin
            e_cmask  = m_acc | coll;
            e_cvalid = 1'b1;
            m_acc    = '0;
        end else begin
            e_cvalid = 1'b0;
            m_acc    = m_acc | coll;
        end
        old_pend = m_pend;
        if (old_pend && sof) begin
            m_en[m_sh_l] = m_sh_e;
            m_rk[m_sh_l] = m_sh_r;
            m_pend       = 1'b0;
        end
        if (!old_pend && cfg_v && int'(cfg_l) < N) begin
            m_pend = 1'b1;
            m_sh_l = int'(cfg_l);
            m_sh_e = int'(cfg_e);
            m_sh_r = int'(cfg_r);
        end
        e_ready = !m_pend;
        @(posedge clk);
        #1;
        check_all(where);
        sof   = 1'b0;
        cfg_v = 1'b0;
    endtask

    task automatic cfg_write(input int layer, input int en, input int rank);
        cfg_v = 1'b1;
        cfg_l = IW'(layer);
        cfg_e = en[0];
        cfg_r = IW'(rank);
    endtask

    task automatic tick5();
        @(posedge clk);
        #1;
        sof5   = 1'b0;
        cfg_v5 = 1'b0;
    endtask

    // Global time limit
    initial begin
        #2000000;
        $display("FAIL timeout checks=%0d", n_checks);
        $fatal(1, "time limit reached");
    end

    initial begin
        resetN = 1'b0;
        sof = 1'b0; req = '0; rgb_in = '0; bg = '0;
        cfg_v = 1'b0; cfg_l = '0; cfg_e = 1'b0; cfg_r = '0;
        sof5 = 1'b0; req5 = '0; rgb_in5 = '0;
        cfg_v5 = 1'b0; cfg_l5 = '0; cfg_e5 = 1'b0; cfg_r5 = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        @(negedge clk);
        resetN = 1'b1;

        // Default ranks: layer1 beats layer2
        rgb_in = {8'h77, 8'h1C, 8'hE0, 8'h55};
        bg     = 8'h03;
        req    = 4'b0110;
        step("dflt");
        check("dflt_rgb_e0", 32'(rgb_out), 32'h0E0);
        check("dflt_wl1", 32'(wl), 32'd1);
        req = 4'b0000;
        step("bg");
        check("bg_rgb_03", 32'(rgb_out), 32'h03);

        // Deferred rank change: layer2 rank 0
        req = 4'b0110;
        cfg_write(2, 1, 0);
        step("rank_wr");
        check("rank_wr_ready0", 32'(cfg_rdy), 32'd0);
        step("rank_mid");
        check("rank_mid_old", 32'(rgb_out), 32'h0E0);
        sof = 1'b1;
        step("rank_sof");
        check("rank_sof_old", 32'(rgb_out), 32'h0E0);
        check("rank_sof_ready1", 32'(cfg_rdy), 32'd1);
        step("rank_new");
        check("rank_new_1c", 32'(rgb_out), 32'h01C);

        // Disable layer0
        req = 4'b0000;
        cfg_write(0, 0, 0);
        step("dis_wr");
        sof = 1'b1;
        step("dis_sof");
        req = 4'b0001;
        step("dis_0001");
        check("dis_bg", 32'(rgb_out), 32'h03);
        check("dis_wv0", 32'(wv), 32'd0);
        req = 4'b0011;
        step("dis_0011");
        check("dis_wl1", 32'(wl), 32'd1);
        req = 4'b0000;
        sof = 1'b1;
        step("dis_bound");
        check("dis_cmask0", 32'(cmask), 32'd0);

        // Re-enable layer0 at rank 0, then the collision latch frame
        cfg_write(0, 1, 0);
        step("reen_wr");
        sof = 1'b1;
        step("reen_sof");
        req = 4'b1010;
        repeat (3) step("coll_1010");
        req = 4'b0101;
        sof = 1'b1;
        step("coll_sof");
        check("coll_mask_f", 32'(cmask), 32'hF);
        check("coll_valid1", 32'(cvalid), 32'd1);
        req = 4'b0001;
        step("coll_after");
        check("coll_valid0", 32'(cvalid), 32'd0);
        step("coll_quiet");
        sof = 1'b1;
        step("coll_sof2");
        check("coll_mask_0", 32'(cmask), 32'd0);

        // Write during a startOfFrame cycle waits for the second boundary
        req = 4'b1000;
        sof = 1'b1;
        cfg_write(3, 0, 3);
        step("sim_sof1");
        check("sim_ready0", 32'(cfg_rdy), 32'd0);
        step("sim_mid");
        check("sim_still_l3", 32'(wl), 32'd3);
        sof = 1'b1;
        step("sim_sof2");
        step("sim_applied");
        check("sim_l3_off", 32'(wv), 32'd0);

        // Asynchronous reset while a write is pending
        req = 4'b0110;
        cfg_write(1, 0, 3);
        step("rst_wr");
        #2;
        resetN = 1'b0;
        #1;
        model_reset();
        check_all("rst_async");
        @(negedge clk);
        resetN = 1'b1;
        req = 4'b0110;
        rgb_in = {8'h77, 8'h1C, 8'hE0, 8'h55};
        step("rst_after");
        check("rst_dflt_e0", 32'(rgb_out), 32'h0E0);

        // Random traffic against the model
        for (int c = 0; c < 2000; c++) begin
            req    = N'($urandom_range(0, 15));
            rgb_in = $urandom;
            bg     = W'($urandom_range(0, 255));
            sof    = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 3) == 0) begin
                cfg_write($urandom_range(0, N - 1), ($urandom_range(0, 3) != 0) ? 1 : 0,
                          $urandom_range(0, N - 1));
            end
            step("rand");
        end

        // 5-layer instance: out-of-range layers are accepted and dropped
        rgb_in5 = {8'h44, 8'h33, 8'h22, 8'h11, 8'h00};
        check("n5_ready_init", 32'(cfg_rdy5), 32'd1);
        cfg_v5 = 1'b1; cfg_l5 = 3'd5; cfg_e5 = 1'b0; cfg_r5 = 3'd0;
        tick5();
        check("n5_l5_ready", 32'(cfg_rdy5), 32'd1);
        cfg_v5 = 1'b1; cfg_l5 = 3'd7; cfg_e5 = 1'b0; cfg_r5 = 3'd0;
        tick5();
        check("n5_l7_ready", 32'(cfg_rdy5), 32'd1);
        sof5 = 1'b1;
        tick5();
        req5 = 5'b00011;
        tick5();
        check("n5_l0_wins", 32'(wl5), 32'd0);
        check("n5_l0_valid", 32'(wv5), 32'd1);
        cfg_v5 = 1'b1; cfg_l5 = 3'd4; cfg_e5 = 1'b1; cfg_r5 = 3'd0;
        req5 = 5'b10010;
        tick5();
        check("n5_l4_ready0", 32'(cfg_rdy5), 32'd0);
        check("n5_l1_before", 32'(wl5), 32'd1);
        sof5 = 1'b1;
        tick5();
        check("n5_ready1", 32'(cfg_rdy5), 32'd1);
        tick5();
        check("n5_l4_wins", 32'(wl5), 32'd4);
        check("n5_l4_rgb", 32'(rgb_out5), 32'h44);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/layer_priority_arbiter.md
# layer_priority_arbiter

Per-pixel arbiter for sprite layers in the pinball video path. Each cycle it picks one winning layer from up to NUM_LAYERS drawing requests using a configurable rank table, and registers that layer's colour, or the background colour when nothing wins, onto RGBOut. Rank and enable changes are double-buffered and applied only at frame boundaries to prevent tearing. Per-frame overlap between layers is latched and reported for the game-logic collision handling.

## Interface
Parameters:
- NUM_LAYERS, 4, number of sprite requesters (legal range 2..8)
- RGB_W, 8, colour width per pixel

Ports:
- clk  in  1  pixel clock
- resetN  in  1  asynchronous, active-low reset
- startOfFrame  in  1  one-cycle pulse from the VGA timing block
- drawingRequest  in  NUM_LAYERS  bit i: layer i covers the current pixel
- layerRGB  in  NUM_LAYERS*RGB_W  layer i colour at [i*RGB_W +: RGB_W]
- backGroundRGB  in  RGB_W  colour used when no layer wins
- cfgValid  in  1  configuration write request
- cfgReady  out  1  write is accepted when cfgValid && cfgReady
- cfgLayer  in  IW  target layer; IW = $clog2(NUM_LAYERS)
- cfgEnable  in  1  new enable value for the target layer
- cfgRank  in  IW  new rank for the target layer; lower rank wins
- RGBOut  out  RGB_W  registered pixel colour
- winnerValid  out  1  registered; a layer won this pixel
- winnerLayer  out  IW  registered index of the winning layer (0 when winnerValid=0)
- collisionMask  out  NUM_LAYERS  latched overlap flags for the frame just ended
- collisionValid  out  1  one-cycle pulse when collisionMask updates

## Operation
- Eligible layer: drawingRequest[i] && activeEnable[i].
- Winner: the eligible layer with the smallest activeRank. Equal ranks go to the lower index.
- No eligible layer: RGBOut <= backGroundRGB, winnerValid <= 0, winnerLayer <= 0.
- Reset values:
  - activeEnable = all 1; activeRank[i] = i.
  - RGBOut = 0; winnerValid = 0; winnerLayer = 0.
  - collisionMask = 0; collisionValid = 0; internal accumulator = 0.
  - Config FSM in IDLE, so cfgReady = 1.
- Config FSM has two states: IDLE and PENDING.
  - IDLE, cfgReady=1. An accepted write with cfgLayer < NUM_LAYERS stores {layer, enable, rank} in the shadow register and moves to PENDING.
  - IDLE, cfgLayer >= NUM_LAYERS: the write is accepted and discarded; the FSM stays in IDLE.
  - PENDING, cfgReady=0. On the clock edge that ends a startOfFrame cycle, the shadow entry is copied into the active tables and the FSM returns to IDLE.
  - Result: at most one applied write per frame.
- cfgValid && startOfFrame in the same cycle while in IDLE: the write is captured, then applied at the next startOfFrame, not the current one.
- Collision accumulator:
  - Bit i is set in any cycle where layer i is eligible and at least one other layer is also eligible.
  - Disabled layers never collide.
- Frame boundary, on the edge ending a startOfFrame cycle:
  - collisionMask <= accumulator | current-cycle collisions.
  - collisionValid <= 1 for one cycle.
  - accumulator <= 0.
- Mid-operation reset returns everything to the reset values and discards any pending write.

## Timing
- Pixel path latency is 1 cycle: inputs in cycle N appear on RGBOut, winnerValid and winnerLayer in cycle N+1. Fully pipelined, one pixel per clock, no stalls.
- The startOfFrame cycle belongs to the outgoing frame:
  - Its pixel is arbitrated with the old tables.
  - Its collisions are counted in the outgoing mask.
- New tables take effect for inputs sampled from cycle S+1, where S is the startOfFrame cycle.
- collisionMask and collisionValid update in cycle S+1. collisionMask then holds its value until the next boundary.
- cfgReady drops in the cycle after acceptance. It rises in cycle S+1.

## Structure
- Shared package objects_pkg holds:
  - RGB_W default.
  - Typedef cfg_state_t {IDLE, PENDING}.
  - The reset default rank function (rank = index).
- Sub-module layer_priority_select: purely combinational. Inputs are the eligible mask and rank table; outputs are winnerValid and winnerLayer. The lower-index tie rule lives here.
- Top level holds the active and shadow tables, the config FSM, the collision accumulator and the output registers.

## Test plan
- Reset defaults: NUM_LAYERS=4, requests 4'b0110 with layer1 colour 8'hE0 and layer2 colour 8'h1C -> next cycle RGBOut=8'hE0, winnerLayer=1, winnerValid=1. Requests 0 with background 8'h03 -> RGBOut=8'h03, winnerValid=0.
- Deferred rank change: write layer2 rank 0 mid-frame -> cfgReady=0 and layer1 still wins until the startOfFrame pulse. From cycle S+1, requests 4'b0110 -> RGBOut=8'h1C. cfgReady returns to 1 in cycle S+1.
- Disable: write layer0 enable=0 and apply it. Requests 4'b0001 -> background colour and winnerValid=0. Requests 4'b0011 -> layer1 wins, and collisionMask at the next boundary is 4'b0000.
- Collision latch: requests 4'b1010 for 3 cycles in a frame plus 4'b0101 on the startOfFrame cycle -> collisionMask=4'b1111 with a one-cycle collisionValid. The following frame with no overlap -> mask 4'b0000.
- Simultaneous events and invalid writes:
  - cfgValid during the startOfFrame cycle -> write not applied until the second boundary.
  - cfgLayer=5 with NUM_LAYERS=5 (IW=3) -> accepted, discarded, FSM stays IDLE.
- Reset mid-PENDING: assert resetN=0 asynchronously -> outputs are 0 immediately, ranks default, pending write lost, cfgReady=1 after release.
